// File: rtl/cv_uart_rx.sv
// cv_uart_rx: oversampling 8E1 UART receiver producing {frame_err, parity_err, data} with a one-cycle strobe.
module cv_uart_rx #(
  parameter int CLK_DIV    = 416,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RXD,
  output logic       RX_DATA_EN,
  output logic [9:0] RX_DATA,
  output logic       BUSY
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic [15:0] HALF = 16'(CLK_DIV / 2 - 1);
  localparam logic [15:0] FULL = 16'(CLK_DIV - 1);
  state_t      r_state;
  logic        r_rxs_m, r_rxs, r_rxs_d;
  logic [15:0] r_baud;
  logic [2:0]  r_bit;
  logic [7:0]  r_data;
  logic        r_perr;
  logic        w_fall, w_tick;
  assign w_fall = r_rxs_d & ~r_rxs;
  assign w_tick = (r_state != IDLE) && (r_baud == 16'd0);
  always_ff @(posedge CLK) begin
    if (RST) begin
      {r_rxs_d, r_rxs, r_rxs_m} <= 3'b111;
      r_state    <= IDLE;
      r_baud     <= '0;
      r_bit      <= '0;
      r_data     <= '0;
      r_perr     <= 1'b0;
      RX_DATA    <= '0;
      RX_DATA_EN <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      {r_rxs_d, r_rxs, r_rxs_m} <= {r_rxs, r_rxs_m, RXD};
      RX_DATA_EN <= 1'b0;
      // counter parks at zero while idle; the first tick lands mid start bit
      if (r_state == IDLE) r_baud <= w_fall ? HALF : 16'd0;
      else r_baud <= w_tick ? FULL : r_baud - 16'd1;
      case (r_state)
        IDLE: if (w_fall) begin
          r_state <= START;
          BUSY    <= 1'b1;
        end
        START: if (w_tick) begin
          r_state <= r_rxs ? IDLE : DATA;
          BUSY    <= ~r_rxs;
          r_bit   <= '0;
        end
        DATA: if (w_tick) begin
          r_data <= {r_rxs, r_data[7:1]};
          r_bit  <= r_bit + 3'd1;
          if (r_bit == 3'd7) r_state <= PARITY;
        end
        PARITY: if (w_tick) begin
          r_perr  <= ^r_data ^ r_rxs ^ PARITY_ODD;
          r_state <= STOP;
        end
        STOP: if (w_tick) begin
          RX_DATA    <= {~r_rxs, r_perr, r_data};
          RX_DATA_EN <= 1'b1;
          BUSY       <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cv_uart_rx.sv
// tb_cv_uart_rx: directed frames at 16 cycles/bit against hand-computed words and strobe timing.
module tb_cv_uart_rx;
  logic       clk = 1'b0;
  logic       rst, rxd;
  logic       rx_en, busy;
  logic [9:0] rx_data;
  int         n_tests = 0, n_fail = 0;
  int         cyc = 0;
  logic [9:0] pd[$];
  int         pt[$];

  cv_uart_rx #(.CLK_DIV(16), .PARITY_ODD(1'b0)) dut (
    .CLK(clk), .RST(rst), .RXD(rxd),
    .RX_DATA_EN(rx_en), .RX_DATA(rx_data), .BUSY(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rx_en) begin
    pd.push_back(rx_data);
    pt.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // line order: start, d0..d7, parity, stop; first n bits only
  task automatic send(input logic [7:0] d, input logic par, input logic stp, input int n);
    logic [10:0] bits;
    bits = {stp, par, d, 1'b0};
    for (int i = 0; i < n; i++) begin
      rxd = bits[i];
      repeat (16) @(negedge clk);
    end
  endtask

  initial begin
    int t0, np;
    logic seen;
    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data", rx_data, 10'h000);
    chk("rst_en", rx_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    idle(5);

    // two synchronizer cycles precede the edge cycle, so strobe = drive + 2 + 169
    t0 = cyc;
    send(8'h41, 1'b0, 1'b1, 11);
    idle(10);
    chk("f41_pulses", pd.size(), 1);
    if (pd.size() > 0) begin
      chk("f41_data", pd[0], 10'h041);
      chk("f41_latency", pt[0] - t0, 171);
    end
    chk("f41_busy", busy, 1'b0);

    send(8'h41, 1'b1, 1'b1, 11);
    idle(10);
    chk("perr_pulses", pd.size(), 2);
    chk("perr_data", rx_data, 10'h141);

    send(8'h41, 1'b0, 1'b0, 11);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i > 10) seen |= busy;
    end
    chk("ferr_pulses", pd.size(), 3);
    chk("ferr_data", rx_data, 10'h241);
    chk("ferr_no_retrigger", seen, 1'b0);
    idle(20);
    chk("ferr_idle_busy", busy, 1'b0);

    np = pd.size();
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    chk("glitch_busy_set", busy, 1'b1);
    idle(40);
    chk("glitch_pulses", pd.size(), np);
    chk("glitch_data", rx_data, 10'h241);
    chk("glitch_busy", busy, 1'b0);

    send(8'h7E, 1'b0, 1'b1, 4);
    chk("rst_mid_busy_before", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(200);
    chk("rst_mid_pulses", pd.size(), np);
    chk("rst_mid_data", rx_data, 10'h000);
    chk("rst_mid_busy", busy, 1'b0);
    send(8'h33, 1'b0, 1'b1, 11);
    idle(10);
    chk("after_rst_pulses", pd.size(), np + 1);
    chk("after_rst_data", rx_data, 10'h033);

    np = pd.size();
    send(8'h30, 1'b0, 1'b1, 11);
    send(8'h46, 1'b1, 1'b1, 11);
    idle(10);
    chk("b2b_pulses", pd.size(), np + 2);
    if (pd.size() >= np + 2) begin
      chk("b2b_first", pd[np], 10'h030);
      chk("b2b_second", pd[np+1], 10'h046);
      chk("b2b_spacing", pt[np+1] - pt[np], 176);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
